// File: rtl/spi_cmd_arbiter_if.sv
// Signal bundle between spi_cmd_arbiter, its requesters and the shared SPI driver.
// The arbiter uses the master modport; clients and the driver sit on the slave side.
interface spi_cmd_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int SPI_MAXLEN = 16
);
  localparam int W = $clog2(SPI_MAXLEN) + 1;

  logic [N_REQ-1:0]            req;
  logic [N_REQ*W-1:0]          req_n_clks;
  logic [N_REQ*SPI_MAXLEN-1:0] req_tx_data;
  logic [N_REQ-1:0]            gnt;
  logic [N_REQ-1:0]            rsp_valid;
  logic                        rsp_err;
  logic [SPI_MAXLEN-1:0]       rsp_rx_data;
  logic                        busy;

  logic                        drv_rdy;
  logic                        drv_start;
  logic [W-1:0]                drv_n_clks;
  logic [SPI_MAXLEN-1:0]       drv_tx_data;
  logic                        drv_done;
  logic [SPI_MAXLEN-1:0]       drv_rx_data;
  logic                        drv_abort;

  modport master (
    input  req, req_n_clks, req_tx_data, drv_rdy, drv_done, drv_rx_data,
    output gnt, rsp_valid, rsp_err, rsp_rx_data, busy,
           drv_start, drv_n_clks, drv_tx_data, drv_abort
  );

  modport slave (
    output req, req_n_clks, req_tx_data, drv_rdy, drv_done, drv_rx_data,
    input  gnt, rsp_valid, rsp_err, rsp_rx_data, busy,
           drv_start, drv_n_clks, drv_tx_data, drv_abort
  );
endinterface

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter that shares one SPI driver among N_REQ requesters,
// validates each command, launches it, supervises a timeout and returns the response.
module spi_cmd_arbiter #(
  parameter int N_REQ          = 4,
  parameter int SPI_MAXLEN     = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              sresetn,
  spi_cmd_arbiter_if.master bus
);
  localparam int W  = $clog2(SPI_MAXLEN) + 1;
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LAUNCH,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [IW-1:0]         rrPtr_q, rrPtr_d;
  logic [IW-1:0]         winIdx_q, winIdx_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic                  err_q, err_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic [N_REQ-1:0]      rspValid_q, rspValid_d;
  logic                  rspErr_q, rspErr_d;
  logic [SPI_MAXLEN-1:0] rspRx_q, rspRx_d;
  logic                  busy_q, busy_d;
  logic                  drvStart_q, drvStart_d;
  logic                  drvAbort_q, drvAbort_d;
  logic [W-1:0]          drvNClks_q, drvNClks_d;
  logic [SPI_MAXLEN-1:0] drvTx_q, drvTx_d;

  logic [W-1:0]          nClksArr [N_REQ];
  logic [SPI_MAXLEN-1:0] txArr    [N_REQ];
  logic                  pickValid;
  logic [IW-1:0]         pickIdx;
  int                    cand;
  logic                  lenBad;
  logic                  timeoutHit;

  genvar g;
  generate
    for (g = 0; g < N_REQ; g++) begin : gUnpack
      assign nClksArr[g] = bus.req_n_clks[g*W +: W];
      assign txArr[g]    = bus.req_tx_data[g*SPI_MAXLEN +: SPI_MAXLEN];
    end
  endgenerate

  // First active request at or above the round-robin pointer, wrapping around.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(rrPtr_q) + k;
      if (cand >= N_REQ) begin
        cand = cand - N_REQ;
      end
      if (!pickValid && bus.req[IW'(cand)]) begin
        pickValid = 1'b1;
        pickIdx   = IW'(cand);
      end
    end
  end

  assign lenBad     = (drvNClks_q == '0) || (drvNClks_q > W'(SPI_MAXLEN));
  assign timeoutHit = (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge sresetn) begin
    if (!sresetn) begin
      state_q    <= ST_IDLE;
      rrPtr_q    <= '0;
      winIdx_q   <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      gnt_q      <= '0;
      rspValid_q <= '0;
      rspErr_q   <= 1'b0;
      rspRx_q    <= '0;
      busy_q     <= 1'b0;
      drvStart_q <= 1'b0;
      drvAbort_q <= 1'b0;
      drvNClks_q <= '0;
      drvTx_q    <= '0;
    end else begin
      state_q    <= state_d;
      rrPtr_q    <= rrPtr_d;
      winIdx_q   <= winIdx_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      gnt_q      <= gnt_d;
      rspValid_q <= rspValid_d;
      rspErr_q   <= rspErr_d;
      rspRx_q    <= rspRx_d;
      busy_q     <= busy_d;
      drvStart_q <= drvStart_d;
      drvAbort_q <= drvAbort_d;
      drvNClks_q <= drvNClks_d;
      drvTx_q    <= drvTx_d;
    end
  end

  // Pulses default low each cycle; the latched command fields hold until the next grant.
  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    winIdx_d   = winIdx_q;
    timer_d    = timer_q;
    err_d      = err_q;
    gnt_d      = '0;
    rspValid_d = '0;
    rspErr_d   = 1'b0;
    rspRx_d    = rspRx_q;
    drvStart_d = 1'b0;
    drvAbort_d = 1'b0;
    drvNClks_d = drvNClks_q;
    drvTx_d    = drvTx_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pickValid && bus.drv_rdy) begin
          winIdx_d         = pickIdx;
          gnt_d[pickIdx]   = 1'b1;
          drvNClks_d       = nClksArr[pickIdx];
          drvTx_d          = txArr[pickIdx];
          err_d            = 1'b0;
          state_d          = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (lenBad) begin
          err_d   = 1'b1;
          rspRx_d = '0;
          state_d = ST_RESP;
        end else begin
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        drvStart_d = 1'b1;
        timer_d    = '0;
        state_d    = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + 1'b1;
        // A completion in the final timeout cycle still counts as success.
        if (bus.drv_done) begin
          rspRx_d = bus.drv_rx_data;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (timeoutHit) begin
          drvAbort_d = 1'b1;
          rspRx_d    = '0;
          err_d      = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        rspValid_d[winIdx_q] = 1'b1;
        rspErr_d             = err_q;
        if (winIdx_q == IW'(N_REQ - 1)) begin
          rrPtr_d = '0;
        end else begin
          rrPtr_d = winIdx_q + 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign bus.gnt         = gnt_q;
  assign bus.rsp_valid   = rspValid_q;
  assign bus.rsp_err     = rspErr_q;
  assign bus.rsp_rx_data = rspRx_q;
  assign bus.busy        = busy_q;
  assign bus.drv_start   = drvStart_q;
  assign bus.drv_abort   = drvAbort_q;
  assign bus.drv_n_clks  = drvNClks_q;
  assign bus.drv_tx_data = drvTx_q;
endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed bench for spi_cmd_arbiter; the bench itself plays the SPI driver with
// hand-timed drv_done pulses, and every expected value is written out by hand.
module tb_spi_cmd_arbiter;
  localparam int N_REQ   = 4;
  localparam int MAXLEN  = 16;
  localparam int TIMEOUT = 32;
  localparam int W       = $clog2(MAXLEN) + 1;

  logic clk;
  logic sresetn;
  int   checks = 0;
  int   errors = 0;
  int   startCount = 0;
  int   abortCount = 0;
  int   gntCount = 0;
  int   rspCount = 0;
  int   base;

  spi_cmd_arbiter_if #(.N_REQ(N_REQ), .SPI_MAXLEN(MAXLEN)) bus ();

  spi_cmd_arbiter #(
    .N_REQ(N_REQ),
    .SPI_MAXLEN(MAXLEN),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk(clk),
    .sresetn(sresetn),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.drv_start) startCount++;
    if (bus.drv_abort) abortCount++;
    if (bus.gnt != '0) gntCount++;
    if (bus.rsp_valid != '0) rspCount++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200us");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] reqV, input int idx, input int nClks,
                               input logic [MAXLEN-1:0] tx);
    bus.req_n_clks[idx*W +: W]             = W'(nClks);
    bus.req_tx_data[idx*MAXLEN +: MAXLEN] = tx;
    bus.req                               = reqV;
  endtask

  // sel: 0 = any gnt, 1 = drv_start, 2 = any rsp_valid
  task automatic waitEvent(input string tag, input int sel, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if ((sel == 0 && bus.gnt != '0) || (sel == 1 && bus.drv_start) ||
          (sel == 2 && bus.rsp_valid != '0)) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(tag, 32'(seen), 32'h1);
  endtask

  initial begin
    sresetn         = 1'b0;
    bus.req         = '0;
    bus.req_n_clks  = '0;
    bus.req_tx_data = '0;
    bus.drv_rdy     = 1'b1;
    bus.drv_done    = 1'b0;
    bus.drv_rx_data = '0;

    // Reset state
    repeat (3) step();
    checkOutput("rst_busy", 32'(bus.busy), 32'h0);
    checkOutput("rst_gnt", 32'(bus.gnt), 32'h0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    checkOutput("rst_rsp_err", 32'(bus.rsp_err), 32'h0);
    checkOutput("rst_rsp_rx", 32'(bus.rsp_rx_data), 32'h0);
    checkOutput("rst_drv_start", 32'(bus.drv_start), 32'h0);
    checkOutput("rst_drv_abort", 32'(bus.drv_abort), 32'h0);
    checkOutput("rst_drv_n_clks", 32'(bus.drv_n_clks), 32'h0);
    checkOutput("rst_drv_tx", 32'(bus.drv_tx_data), 32'h0);
    sresetn = 1'b1;
    step();

    // Single transfer on requester 0; other slices hold decoy values
    applyStimulus(4'b0000, 1, 3, 16'h1111);
    applyStimulus(4'b0000, 2, 5, 16'h2222);
    applyStimulus(4'b0000, 3, 7, 16'h3333);
    applyStimulus(4'b0001, 0, 8, 16'h00A5);
    base = abortCount;
    step();
    checkOutput("t1_gnt", 32'(bus.gnt), 32'h1);
    checkOutput("t1_busy", 32'(bus.busy), 32'h1);
    checkOutput("t1_n_clks", 32'(bus.drv_n_clks), 32'd8);
    checkOutput("t1_tx", 32'(bus.drv_tx_data), 32'h00A5);
    bus.req = '0;
    step();
    checkOutput("t1_no_early_start", 32'(bus.drv_start), 32'h0);
    step();
    checkOutput("t1_start", 32'(bus.drv_start), 32'h1);
    repeat (9) step();
    bus.drv_done    = 1'b1;
    bus.drv_rx_data = 16'h005A;
    step();
    bus.drv_done = 1'b0;
    checkOutput("t1_rsp_not_yet", 32'(bus.rsp_valid), 32'h0);
    step();
    checkOutput("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    checkOutput("t1_rsp_err", 32'(bus.rsp_err), 32'h0);
    checkOutput("t1_rsp_rx", 32'(bus.rsp_rx_data), 32'h005A);
    checkOutput("t1_busy_done", 32'(bus.busy), 32'h0);
    checkOutput("t1_no_abort", 32'(abortCount - base), 32'h0);

    // Timeout on requester 1 (pointer now at 1)
    applyStimulus(4'b0010, 1, 8, 16'h1234);
    step();
    checkOutput("to_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    step();
    step();
    checkOutput("to_start", 32'(bus.drv_start), 32'h1);
    base = abortCount;
    repeat (TIMEOUT - 1) step();
    checkOutput("to_abort_not_early", 32'(abortCount - base), 32'h0);
    step();
    checkOutput("to_abort", 32'(bus.drv_abort), 32'h1);
    step();
    checkOutput("to_abort_one_cycle", 32'(bus.drv_abort), 32'h0);
    checkOutput("to_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    checkOutput("to_rsp_err", 32'(bus.rsp_err), 32'h1);
    checkOutput("to_rsp_rx", 32'(bus.rsp_rx_data), 32'h0);

    // drv_rdy gating, then done coinciding with the last timeout cycle
    bus.drv_rdy = 1'b0;
    applyStimulus(4'b0100, 2, 6, 16'h0F0F);
    base = gntCount;
    repeat (5) step();
    checkOutput("gate_no_gnt", 32'(gntCount - base), 32'h0);
    checkOutput("gate_idle", 32'(bus.busy), 32'h0);
    bus.drv_rdy = 1'b1;
    step();
    checkOutput("gate_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    step();
    step();
    checkOutput("race_start", 32'(bus.drv_start), 32'h1);
    base = abortCount;
    repeat (TIMEOUT - 1) step();
    bus.drv_done    = 1'b1;
    bus.drv_rx_data = 16'h3C3C;
    step();
    bus.drv_done = 1'b0;
    checkOutput("race_no_abort", 32'(bus.drv_abort), 32'h0);
    step();
    checkOutput("race_rsp_valid", 32'(bus.rsp_valid), 32'h4);
    checkOutput("race_rsp_err", 32'(bus.rsp_err), 32'h0);
    checkOutput("race_rsp_rx", 32'(bus.rsp_rx_data), 32'h3C3C);
    checkOutput("race_abort_count", 32'(abortCount - base), 32'h0);

    // Reset while waiting for the driver (pointer now at 3)
    applyStimulus(4'b1000, 3, 8, 16'h5555);
    step();
    checkOutput("mid_gnt", 32'(bus.gnt), 32'h8);
    bus.req = '0;
    step();
    step();
    checkOutput("mid_start", 32'(bus.drv_start), 32'h1);
    repeat (5) step();
    base = rspCount;
    sresetn = 1'b0;
    #1;
    checkOutput("mid_busy_async", 32'(bus.busy), 32'h0);
    checkOutput("mid_tx_cleared", 32'(bus.drv_tx_data), 32'h0);
    repeat (3) step();
    sresetn = 1'b1;
    repeat (2) step();
    checkOutput("mid_no_rsp", 32'(rspCount - base), 32'h0);

    // Round robin with all requests held; reset put the pointer back at 0
    for (int i = 0; i < N_REQ; i++) begin
      applyStimulus(4'b0000, i, 4, 16'(16'hA000 + i));
    end
    base = startCount;
    bus.req = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      waitEvent("rr_gnt_seen", 0, 20);
      checkOutput($sformatf("rr_gnt_%0d", g), 32'(bus.gnt), 32'h1 << (g % N_REQ));
      checkOutput($sformatf("rr_tx_%0d", g), 32'(bus.drv_tx_data), 32'(16'hA000 + (g % N_REQ)));
      waitEvent("rr_start_seen", 1, 10);
      step();
      bus.drv_done    = 1'b1;
      bus.drv_rx_data = 16'(16'h1000 + g);
      step();
      bus.drv_done = 1'b0;
      waitEvent("rr_rsp_seen", 2, 10);
      checkOutput($sformatf("rr_rsp_%0d", g), 32'(bus.rsp_valid), 32'h1 << (g % N_REQ));
      checkOutput($sformatf("rr_rx_%0d", g), 32'(bus.rsp_rx_data), 32'(16'h1000 + g));
    end
    bus.req = '0;
    checkOutput("rr_start_count", 32'(startCount - base), 32'd5);

    // Length checks (pointer now at 1): zero length, then 17 bits
    base = startCount;
    applyStimulus(4'b0010, 1, 0, 16'hBEEF);
    step();
    checkOutput("len0_gnt", 32'(bus.gnt), 32'h2);
    bus.req = '0;
    step();
    step();
    checkOutput("len0_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    checkOutput("len0_rsp_err", 32'(bus.rsp_err), 32'h1);
    applyStimulus(4'b0000, 1, 8, 16'h0101);
    applyStimulus(4'b0110, 2, 17, 16'h0202);
    step();
    checkOutput("len17_gnt_rr", 32'(bus.gnt), 32'h4);
    checkOutput("len17_n_clks", 32'(bus.drv_n_clks), 32'd17);
    bus.req = '0;
    step();
    step();
    checkOutput("len17_rsp_valid", 32'(bus.rsp_valid), 32'h4);
    checkOutput("len17_rsp_err", 32'(bus.rsp_err), 32'h1);
    checkOutput("len_no_start", 32'(startCount - base), 32'h0);
    checkOutput("len_busy", 32'(bus.busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_cmd_arbiter.md
Name: spi_cmd_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one SPI driver between N_REQ requesters.
- Accepts one transfer command per requester, validates it and launches it on the driver's command interface.
- Waits for completion or timeout, then returns MISO data and status to the winning requester.
- Sits between the SPI driver and client logic (sensor pollers, config engine), all in the clk domain.

Parameters:
N_REQ, 4, number of requesters (2..8)
SPI_MAXLEN, 16, maximum SPI transfer length in bits; must match the driver
TIMEOUT_CYCLES, 4096, clk cycles allowed between drv_start and drv_done before abort

Ports:
clk  in  1  system clock
sresetn  in  1  asynchronous active-low reset
req  in  N_REQ  per-requester request level; hold until gnt
req_n_clks  in  N_REQ*W  per-requester bit count, W=$clog2(SPI_MAXLEN)+1; slice i = bits [i*W +: W]
req_tx_data  in  N_REQ*SPI_MAXLEN  per-requester MOSI data; slice i = bits [i*SPI_MAXLEN +: SPI_MAXLEN]
gnt  out  N_REQ  one-hot, 1-cycle pulse; command of that requester latched
rsp_valid  out  N_REQ  one-hot, 1-cycle pulse; response for that requester
rsp_err  out  1  qualifies rsp_valid: 1 = rejected or timed out
rsp_rx_data  out  SPI_MAXLEN  MISO data; valid while any rsp_valid bit is 1
busy  out  1  1 whenever state != IDLE
drv_rdy  in  1  driver idle and able to accept start
drv_start  out  1  1-cycle start pulse to driver
drv_n_clks  out  W  latched bit count to driver
drv_tx_data  out  SPI_MAXLEN  latched MOSI data to driver
drv_done  in  1  1-cycle pulse; driver finished, drv_rx_data valid
drv_rx_data  in  SPI_MAXLEN  received data from driver
drv_abort  out  1  1-cycle pulse; driver must drop SS_N and return to idle

Behaviour:
- Reset (async assert, sync release): state=IDLE, rr_ptr=0, timer=0; gnt, rsp_valid, rsp_err, drv_start, drv_abort, busy=0; rsp_rx_data, drv_n_clks, drv_tx_data=0.
- All outputs are registered.
- FSM states: IDLE, CHECK, LAUNCH, WAIT, RESP.
- IDLE:
  - Advance only if |req and drv_rdy are both 1.
  - Winner w = first set req bit searching upward from rr_ptr, wrapping at N_REQ.
  - Next cycle: gnt[w]=1, drv_n_clks/drv_tx_data latch slice w, state goes to CHECK.
  - If drv_rdy=0, remain in IDLE regardless of req.
- CHECK:
  - drv_n_clks==0 or drv_n_clks>SPI_MAXLEN: go to RESP with error set; no drv_start is issued.
  - Otherwise go to LAUNCH.
- LAUNCH: drv_start=1 for exactly one cycle, timer cleared, go to WAIT.
- WAIT:
  - Timer increments each cycle.
  - drv_done=1: capture drv_rx_data, clear error, go to RESP.
  - Timer reaches TIMEOUT_CYCLES-1 without drv_done: drv_abort=1 for one cycle, rsp_rx_data=0, error set, go to RESP.
  - drv_done and timeout in the same cycle: drv_done wins, no abort.
- RESP:
  - rsp_valid[w]=1 for one cycle, with rsp_err = error flag.
  - rr_ptr=(w+1) mod N_REQ; this also happens on error.
  - Go to IDLE.
- Best-case latency: req sampled in cycle N gives gnt at N+1 and drv_start at N+3; rsp_valid arrives 2 cycles after drv_done.
- req is re-sampled only in IDLE. A requester that still holds req after its rsp_valid is treated as a new request.
- Commands and requests in any state other than IDLE are ignored; they are never queued.
- drv_done outside WAIT is ignored.
- Latched command fields stay stable from gnt until RESP exits.
- Reset mid-transfer returns everything to reset values immediately; no response is issued for the in-flight command.

Test Plan:
- Single transfer: req=4'b0001, n_clks=8, tx=16'h00A5; drv_done after 10 cycles with rx=16'h005A. Expect gnt[0] at N+1, drv_start at N+3, drv_n_clks=8, rsp_valid[0] with rsp_err=0 and rsp_rx_data=16'h005A.
- Round robin: req=4'b1111 held continuously. Expect grant order 0,1,2,3,0, with exactly one drv_start per grant.
- Length check: n_clks=0, then n_clks=17 (SPI_MAXLEN=16). Expect gnt, then rsp_valid with rsp_err=1, no drv_start, and rr_ptr advanced.
- Timeout: TIMEOUT_CYCLES=32 and drv_done never asserted. Expect drv_abort exactly 32 cycles after drv_start is observed in WAIT, then rsp_err=1 and rsp_rx_data=0.
- Gating: drv_rdy=0 with req=4'b0100 pending. Expect no gnt until drv_rdy rises, then gnt[2] on the next cycle. Also check that drv_done and timeout in the same cycle yield rsp_err=0 and no drv_abort.
- Reset: assert sresetn=0 during WAIT. Expect busy=0 immediately, no rsp_valid, and rr_ptr=0 after release, so the next grant goes to requester 0.
